// File: rtl/sram_cmd_master.sv
// Burst command sequencer driving a single-port SRAM (we/re/addr/data, registered datao).
// Define SRAM_MASTER_READBACK_VERIFY_EN to re-read and compare every written word.
module sram_cmd_master #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 9,
   parameter int MEM_DEPTH = 9,
   parameter int LEN_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_last,
   output logic              cmd_err,
   output logic              busy,
   output logic              vfy_err,
   output logic [ADDR_W-1:0] vfy_err_addr,
   output logic              sram_we,
   output logic              sram_re,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_data,
   input  logic [DATA_W-1:0] sram_datao
);

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  ONE_L   = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_WAIT,
      S_WR_PULSE,
      S_RD_PULSE,
      S_RD_CAPT,
      S_RD_RESP
`ifdef SRAM_MASTER_READBACK_VERIFY_EN
      ,
      S_VFY_PULSE,
      S_VFY_CAPT
`endif
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [LEN_W-1:0]  beats_q;
   logic              last_beat_s;
   logic              cmd_ready_q;
   logic              wdata_ready_q;
   logic              rdata_valid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rdata_last_q;
   logic              cmd_err_q;
   logic              busy_q;
   logic              sram_we_q;
   logic              sram_re_q;
   logic [ADDR_W-1:0] sram_addr_q;
   logic [DATA_W-1:0] sram_data_q;
`ifdef SRAM_MASTER_READBACK_VERIFY_EN
   logic [DATA_W-1:0] wdat_q;
   logic              vfy_err_q;
   logic [ADDR_W-1:0] vfy_err_addr_q;
`endif

   // Next beat address wraps at the memory depth rather than the address-space size.
   always_comb begin
      addr_d = addr_q + ONE_A;
      if (addr_q == LAST_A) begin
         addr_d = {ADDR_W{1'b0}};
      end else begin
         addr_d = addr_q + ONE_A;
      end
   end

   assign last_beat_s = (beats_q == {LEN_W{1'b0}});

   // Sequencer FSM; every output is registered alongside the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         addr_q        <= {ADDR_W{1'b0}};
         beats_q       <= {LEN_W{1'b0}};
         cmd_ready_q   <= 1'b0;
         wdata_ready_q <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= {DATA_W{1'b0}};
         rdata_last_q  <= 1'b0;
         cmd_err_q     <= 1'b0;
         busy_q        <= 1'b0;
         sram_we_q     <= 1'b0;
         sram_re_q     <= 1'b0;
         sram_addr_q   <= {ADDR_W{1'b0}};
         sram_data_q   <= {DATA_W{1'b0}};
`ifdef SRAM_MASTER_READBACK_VERIFY_EN
         wdat_q         <= {DATA_W{1'b0}};
         vfy_err_q      <= 1'b0;
         vfy_err_addr_q <= {ADDR_W{1'b0}};
`endif
      end else begin
         cmd_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!cmd_ready_q) begin
                  cmd_ready_q <= 1'b1;
               end else if (cmd_valid) begin
                  if (cmd_addr >= DEPTH_A) begin
                     cmd_err_q <= 1'b1;
                  end else begin
                     addr_q      <= cmd_addr;
                     beats_q     <= cmd_len;
                     cmd_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                     if (cmd_wr) begin
                        state_q       <= S_WR_WAIT;
                        wdata_ready_q <= 1'b1;
                     end else begin
                        state_q     <= S_RD_PULSE;
                        sram_re_q   <= 1'b1;
                        sram_addr_q <= cmd_addr;
                     end
                  end
               end
            end
            S_WR_WAIT: begin
               if (wdata_valid && wdata_ready_q) begin
                  wdata_ready_q <= 1'b0;
                  sram_we_q     <= 1'b1;
                  sram_addr_q   <= addr_q;
                  sram_data_q   <= wdata;
`ifdef SRAM_MASTER_READBACK_VERIFY_EN
                  wdat_q        <= wdata;
`endif
                  state_q       <= S_WR_PULSE;
               end
            end
            S_WR_PULSE: begin
               sram_we_q <= 1'b0;
`ifdef SRAM_MASTER_READBACK_VERIFY_EN
               sram_re_q <= 1'b1;
               state_q   <= S_VFY_PULSE;
`else
               addr_q  <= addr_d;
               beats_q <= beats_q - ONE_L;
               if (last_beat_s) begin
                  state_q     <= S_IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  state_q       <= S_WR_WAIT;
                  wdata_ready_q <= 1'b1;
               end
`endif
            end
`ifdef SRAM_MASTER_READBACK_VERIFY_EN
            S_VFY_PULSE: begin
               sram_re_q <= 1'b0;
               state_q   <= S_VFY_CAPT;
            end
            S_VFY_CAPT: begin
               // Only the first mismatch address is kept; the flag is sticky.
               if ((sram_datao != wdat_q) && !vfy_err_q) begin
                  vfy_err_q      <= 1'b1;
                  vfy_err_addr_q <= addr_q;
               end
               addr_q  <= addr_d;
               beats_q <= beats_q - ONE_L;
               if (last_beat_s) begin
                  state_q     <= S_IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  state_q       <= S_WR_WAIT;
                  wdata_ready_q <= 1'b1;
               end
            end
`endif
            S_RD_PULSE: begin
               sram_re_q <= 1'b0;
               state_q   <= S_RD_CAPT;
            end
            S_RD_CAPT: begin
               rdata_q       <= sram_datao;
               rdata_last_q  <= last_beat_s;
               rdata_valid_q <= 1'b1;
               state_q       <= S_RD_RESP;
            end
            S_RD_RESP: begin
               if (rdata_ready) begin
                  rdata_valid_q <= 1'b0;
                  rdata_last_q  <= 1'b0;
                  addr_q        <= addr_d;
                  beats_q       <= beats_q - ONE_L;
                  if (last_beat_s) begin
                     state_q     <= S_IDLE;
                     cmd_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q     <= S_RD_PULSE;
                     sram_re_q   <= 1'b1;
                     sram_addr_q <= addr_d;
                  end
               end
            end
            default: begin
               state_q       <= S_IDLE;
               cmd_ready_q   <= 1'b0;
               wdata_ready_q <= 1'b0;
               rdata_valid_q <= 1'b0;
               rdata_last_q  <= 1'b0;
               busy_q        <= 1'b0;
               sram_we_q     <= 1'b0;
               sram_re_q     <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign wdata_ready = wdata_ready_q;
   assign rdata_valid = rdata_valid_q;
   assign rdata       = rdata_q;
   assign rdata_last  = rdata_last_q;
   assign cmd_err     = cmd_err_q;
   assign busy        = busy_q;
   assign sram_we     = sram_we_q;
   assign sram_re     = sram_re_q;
   assign sram_addr   = sram_addr_q;
   assign sram_data   = sram_data_q;
`ifdef SRAM_MASTER_READBACK_VERIFY_EN
   assign vfy_err      = vfy_err_q;
   assign vfy_err_addr = vfy_err_addr_q;
`else
   assign vfy_err      = 1'b0;
   assign vfy_err_addr = {ADDR_W{1'b0}};
`endif

endmodule

// File: doc/sram_cmd_master.md
Name: sram_cmd_master

Overview:
- Initiator side of the single-port SRAM interface (we/re/addr/data in, registered datao out).
- Accepts burst read/write commands on a valid/ready front end and sequences the SRAM strobes.
- Captures SRAM read data one cycle after each re pulse and returns it on a valid/ready response channel.
- Sits between test/stimulus logic and the SRAM instance. SRAM rst is tied to the same rst at top level.

Parameters:
- ADDR_W, 9, SRAM address width.
- DATA_W, 9, SRAM data width.
- MEM_DEPTH, 9, number of valid SRAM words; addresses 0..MEM_DEPTH-1.
- LEN_W, 4, burst length field width; beats = cmd_len+1 (1..16).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_wr  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats minus one.
- wdata_valid  in  1  write beat offered.
- wdata_ready  out  1  write beat accepted on handshake.
- wdata  in  DATA_W  write beat data.
- rdata_valid  out  1  read beat available.
- rdata_ready  in  1  read beat consumed on handshake.
- rdata  out  DATA_W  read beat data.
- rdata_last  out  1  final beat of the read burst.
- cmd_err  out  1  one-cycle pulse: command rejected (cmd_addr >= MEM_DEPTH).
- busy  out  1  state != IDLE.
- vfy_err  out  1  sticky readback mismatch flag (see Optional Feature).
- vfy_err_addr  out  ADDR_W  address of the first mismatch.
- sram_we  out  1  to SRAM we.
- sram_re  out  1  to SRAM re.
- sram_addr  out  ADDR_W  to SRAM addr.
- sram_data  out  DATA_W  to SRAM data.
- sram_datao  in  DATA_W  from SRAM datao; valid the cycle after an sram_re pulse.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0: cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, cmd_err, busy, vfy_err, vfy_err_addr, sram_we, sram_re, sram_addr, sram_data.
  - Internal addr/beat counters are cleared.
- Output timing: sram_we and sram_re are decoded from the state register only (Moore). They are never both 1.
- States: IDLE, WR_WAIT, WR_PULSE, RD_PULSE, RD_CAPT, RD_RESP; VFY_PULSE and VFY_CAPT exist only with the feature.
- IDLE:
  - cmd_ready=1.
  - On handshake with cmd_addr >= MEM_DEPTH: pulse cmd_err next cycle, stay IDLE, make no SRAM access.
  - Otherwise latch addr and beat count; go to WR_WAIT if cmd_wr=1, else RD_PULSE.
- WR_WAIT:
  - wdata_ready=1.
  - On handshake, latch wdata and go to WR_PULSE.
- WR_PULSE:
  - sram_we=1, sram_addr=addr, sram_data=latched data for exactly one cycle.
  - Then go to WR_WAIT, or IDLE after the last beat.
- RD_PULSE: sram_re=1, sram_addr=addr for one cycle, then RD_CAPT.
- RD_CAPT: rdata <= sram_datao, then RD_RESP.
- RD_RESP:
  - rdata_valid=1; rdata_last=1 on the final beat.
  - rdata and rdata_last hold stable until rdata_ready.
  - On handshake go to RD_PULSE, or IDLE after the last beat.
- Latency and throughput:
  - Read: cmd accepted in cycle 0 → sram_re in cycle 1 → rdata_valid in cycle 3. Each further beat takes 3 cycles, assuming rdata_ready=1.
  - Write: one beat per 2 cycles when wdata_valid is held high.
- Address increment: after each beat, addr increments. MEM_DEPTH-1 wraps to 0, not 2^ADDR_W.
- Only one SRAM read is ever in flight. Read backpressure stalls in RD_RESP with no further SRAM access.
- Reset mid-burst:
  - Aborts the burst immediately; the beat in progress is dropped.
  - A WR_PULSE active in the reset cycle is still presented to the SRAM. The SRAM ignores it because its rst is high.
- cmd_valid is ignored while busy=1.

Optional Feature:
- Macro: SRAM_MASTER_READBACK_VERIFY_EN.
- Defined:
  - After each WR_PULSE, insert VFY_PULSE (sram_re=1, same addr) then VFY_CAPT.
  - VFY_CAPT compares sram_datao against the latched write data.
  - On the first mismatch: set vfy_err (sticky until rst) and capture vfy_err_addr. Later mismatches leave vfy_err_addr unchanged.
  - A write beat costs 4 cycles.
- Undefined:
  - No VFY states; a write beat costs 2 cycles.
  - vfy_err and vfy_err_addr are tied to 0.

Test Plan:
- Write then read: write burst addr=2, len=2, data 0x011/0x0A5/0x1FF, then read burst addr=2, len=2 → sram_we pulses at addr 2,3,4; rdata 0x011, 0x0A5, 0x1FF; rdata_last only on 0x1FF; first rdata_valid 3 cycles after read cmd handshake.
- Wrap: write addr=7, len=3, data 1,2,3,4 → SRAM writes at addr 7,8,0,1; reading addr=7, len=3 returns 1,2,3,4.
- Rejected command: cmd_addr=9 → cmd_err pulses once; no sram_we/sram_re; busy stays 0; cmd_ready stays 1.
- Read backpressure: read addr=0, len=1 with rdata_ready=0 for 5 cycles → rdata_valid held with rdata stable; exactly 1 sram_re pulse until the handshake, then the second beat follows.
- Reset mid-burst: write len=15, assert rst after 3 beats → next cycle busy=0, all outputs 0, no further sram_we; a new command afterwards is accepted normally.
- Feature on: model a stuck-at-0 bit on SRAM datao[0], write 0x001 to addr 5 → vfy_err=1, vfy_err_addr=5; a later mismatch at addr 6 leaves vfy_err_addr=5.
